// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache miss interfaces.
// One transaction at a time; the response is steered back to the granted side only.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter bit RR     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

  state_e              state_q, state_d;
  logic                g_q, g_d;
  logic                lg_q, lg_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;

  logic i_req, d_req, win, done;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  // Winner encoding: 1 = D side, 0 = I side.
  always_comb begin
    if (i_req && d_req) begin
      win = RR ? ~lg_q : 1'b1;
    end else begin
      win = d_req;
    end
  end

  assign done = (state_q == BUSY) && m_resp && !reset;

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    lg_d      = lg_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = BUSY;
          g_d     = win;
          lg_d    = win;
          wr_d    = win ? d_write : i_write;
          addr_d  = win ? d_addr  : i_addr;
          wdata_d = win ? d_wdata : i_wdata;
        end
      end
      BUSY: begin
        if (m_resp) begin
          state_d = RELEASE;
          if (g_q) begin
            d_rdata_d = m_rdata;
          end else begin
            i_rdata_d = m_rdata;
          end
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      g_q       <= 1'b0;
      lg_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      lg_q      <= lg_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Strobes come only from the latched op; requester changes mid-transaction are ignored.
  assign m_read  = (state_q == BUSY) && !wr_q;
  assign m_write = (state_q == BUSY) && wr_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  assign i_resp  = done && !g_q;
  assign d_resp  = done && g_q;
  assign i_rdata = (done && !g_q) ? m_rdata : i_rdata_q;
  assign d_rdata = (done && g_q)  ? m_rdata : d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the instruction-side and data-side cache miss ports of the pipelined LC-3b onto the single shared physical memory (or L2) port.
- One transaction at a time; grants, latches and forwards a full line request, then returns the response to the winning requester only.
- Sits between the I-cache/D-cache fill/writeback interfaces and the main memory model.

Parameters:
- ADDR_W, 16, address width (lc3b_word).
- LINE_W, 128, cache line width in bits.
- RR, 0, 0 = fixed priority (D side wins ties); 1 = round-robin (side not granted last wins ties).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high.
- i_read  in  1  I-side line read request.
- i_write  in  1  I-side line write request (tied low by I-cache, still arbitrated).
- i_addr  in  ADDR_W  I-side line address.
- i_wdata  in  LINE_W  I-side write line.
- i_rdata  out  LINE_W  read line returned to I side.
- i_resp  out  1  I-side transaction complete, 1-cycle pulse.
- d_read  in  1  D-side line read request.
- d_write  in  1  D-side line write (writeback) request.
- d_addr  in  ADDR_W  D-side line address.
- d_wdata  in  LINE_W  D-side write line.
- d_rdata  out  LINE_W  read line returned to D side.
- d_resp  out  1  D-side transaction complete, 1-cycle pulse.
- m_read  out  1  memory read strobe.
- m_write  out  1  memory write strobe.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  LINE_W  memory write line.
- m_rdata  in  LINE_W  memory read line.
- m_resp  in  1  memory transaction complete.

Behaviour:
- States: IDLE, BUSY, RELEASE. Registered grant bit g (0 = I, 1 = D), registered last-grant bit lg, latched op/addr/wdata.
- Reset: state IDLE, g=0, lg=0 (so RR first tie goes to D), latched regs 0. m_read=m_write=0, i_resp=d_resp=0, rdata outputs 0 from the first cycle after reset.
- A side is requesting when its read or write is high. If read and write are both high, write is taken.
- IDLE: no request -> stay. Otherwise pick the winner. Tie with RR=0 -> D. Tie with RR=1 -> side != lg. Lone request -> that side.
- On the IDLE -> BUSY edge: latch winner op, addr, wdata; set g; set lg=winner.
- BUSY: drive m_read/m_write from the latched op, m_addr/m_wdata from the latched regs.
  - First memory strobe appears the cycle after the request is seen (1-cycle grant latency).
  - Requester signal changes during BUSY are ignored; the transaction always completes.
- BUSY and m_resp=1: same cycle, assert resp of side g (combinational from m_resp) and drive that side's rdata = m_rdata. Next state RELEASE.
- Non-granted side: resp is never asserted; its rdata holds its last returned value (registered copy).
- RELEASE: one cycle with m_read=m_write=0 and no resp. The requester drops its strobe here, so a stale request cannot be re-granted. Then go to IDLE; a request pending in IDLE is granted as normal.
- Back-to-back: minimum 2 idle cycles of memory strobe between transactions (RELEASE + IDLE arbitration).
- Outside BUSY: m_read=m_write=0. m_addr/m_wdata hold the latched values (don't-care to memory).
- m_resp outside BUSY: ignored, no resp generated.
- Reset asserted mid-BUSY: next cycle IDLE, strobes low, no resp. The aborted transaction is not replayed; memory must also be reset.
- Arbitration is never preemptive: a higher-priority request arriving during BUSY waits for RELEASE -> IDLE.

Test Plan:
- Lone I read of 0x1230; memory responds after 3 cycles with 128'hA5..A5 -> m_read high 1 cycle after the request for 3 cycles, m_addr=0x1230, i_resp 1-cycle pulse with i_rdata=A5..A5, d_resp stays 0.
- D write of 0x4000 (d_wdata=128'h1) concurrent with I read of 0x0010, RR=0 -> D served first (m_write, m_addr=0x4000), RELEASE, IDLE, then I read of 0x0010; each resp goes only to its owner.
- RR=1: both sides request continuously for 4 transactions -> grant order D, I, D, I.
- D drops d_read 1 cycle into BUSY -> m_read held until m_resp, d_resp still pulses, no second transaction issued.
- Reset asserted during BUSY before m_resp -> next cycle m_read=0, no resp pulse, state IDLE; a pending I request is granted afterwards with I winning only if it is the lone requester.
- Spurious m_resp while IDLE -> no i_resp/d_resp, state unchanged.
